// File: rtl/alu_pkg.sv
// Shared types and constants for the shared-ALU block.
//   alu_ctrl_e   : ALU operation encoding (add, sub, and, or, xor)
//   alu_req_t    : one ALU request {ctrl, op1, op2}
//   alu_rsp_t    : one ALU response {result, eq}
//   ctrl_defined : true for encodings the ALU actually implements
package alu_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100
    } alu_ctrl_e;

    typedef struct packed {
        logic [2:0]                    ctrl;
        logic [DEFAULT_DATA_WIDTH-1:0] op1;
        logic [DEFAULT_DATA_WIDTH-1:0] op2;
    } alu_req_t;

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] result;
        logic                          eq;
    } alu_rsp_t;

    function automatic logic ctrl_defined(input logic [2:0] ctrl);
        return ctrl <= 3'b100;
    endfunction

endpackage

// File: rtl/alu.sv
// Existing combinational ALU.
//   ctrl_i        : operation (alu_ctrl_e encoding)
//   op1_i, op2_i  : operands
//   sum_o         : result, modulo 2^WIDTH; unused encodings pass op1 through
//   eq_o          : op1 == op2
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [2:0]       ctrl_i,
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             eq_o
);

    alu_ctrl_e op;
    assign op = alu_ctrl_e'(ctrl_i);

    always_comb begin
        sum_o = op1_i;
        case (op)
            ALU_ADD: sum_o = op1_i + op2_i;
            ALU_SUB: sum_o = op1_i - op2_i;
            ALU_AND: sum_o = op1_i & op2_i;
            ALU_OR:  sum_o = op1_i | op2_i;
            ALU_XOR: sum_o = op1_i ^ op2_i;
            default: sum_o = op1_i;
        endcase
    end

    assign eq_o = (op1_i == op2_i);

endmodule

// File: rtl/alu_rsp_fifo.sv
// Two-entry synchronous response FIFO.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push_i     : write din_i (ignored when full and not popping)
//   pop_i      : drop the head entry (ignored when empty)
//   head_o     : current head entry, stable until popped
//   full_o, empty_o, count_o : occupancy status
module alu_rsp_fifo
    import alu_pkg::*;
#(
    parameter type entry_t = alu_rsp_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  entry_t     din_i,
    input  logic       pop_i,
    output entry_t     head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [1:0] count_o
);

    entry_t     mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between two requesters with round-robin arbitration,
// one operand register stage and a 2-entry response FIFO per port.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : per-port request handshake (bit i = port i)
//   req_ctrl [3*i +: 3]   : port i ALU op
//   req_op1/req_op2       : port i operands at [DATA_WIDTH*i +: DATA_WIDTH]
//   rsp_valid/rsp_ready   : per-port response handshake
//   rsp_result, rsp_eq    : port i FIFO head, driven to 0 when empty
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [5:0]              req_ctrl,
    input  logic [2*DATA_WIDTH-1:0] req_op1,
    input  logic [2*DATA_WIDTH-1:0] req_op2,
    output logic [1:0]              rsp_valid,
    input  logic [1:0]              rsp_ready,
    output logic [2*DATA_WIDTH-1:0] rsp_result,
    output logic [1:0]              rsp_eq
);

    typedef struct packed {
        logic [2:0]            ctrl;
        logic [DATA_WIDTH-1:0] op1;
        logic [DATA_WIDTH-1:0] op2;
    } req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic                  eq;
    } rsp_t;

    logic [1:0] pop;
    logic [1:0] elig;
    logic [1:0] cand;
    logic [1:0] grant;
    logic [1:0] push;
    logic [1:0] fifo_full;
    logic [1:0] fifo_empty;
    logic [1:0] fifo_count_unused [2];
    logic [1:0] occ_q [2];
    logic [1:0] occ_d [2];
    logic       ptr_q, ptr_d;
    logic       s1_valid_q;
    logic       s1_owner_q;
    req_t       s1_q;
    req_t       sel_req;
    rsp_t       alu_rsp;
    rsp_t       fifo_head [2];
    logic [DATA_WIDTH-1:0] alu_sum;
    logic                  alu_eq;

    // A port sitting at full occupancy may still be granted when its head
    // is popped this cycle: rsp_ready feeds req_ready combinationally.
    always_comb begin
        pop  = '0;
        elig = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            pop[i]  = rsp_valid[i] & rsp_ready[i];
            elig[i] = (occ_q[i] < 2'(RSP_DEPTH)) | pop[i];
        end
        cand  = req_valid & elig & {2{rst_n}};
        grant = '0;
        if (cand == 2'b11) begin
            grant[ptr_q] = 1'b1;
        end else begin
            grant = cand;
        end
    end

    assign req_ready = grant;

    always_comb begin
        sel_req.ctrl = req_ctrl[3*grant[1] +: 3];
        sel_req.op1  = req_op1[DATA_WIDTH*grant[1] +: DATA_WIDTH];
        sel_req.op2  = req_op2[DATA_WIDTH*grant[1] +: DATA_WIDTH];
        ptr_d        = (|grant) ? ~grant[1] : ptr_q;
        for (int unsigned i = 0; i < 2; i++) begin
            occ_d[i] = occ_q[i] + 2'(grant[i]) - 2'(pop[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_owner_q <= 1'b0;
            s1_q       <= '0;
            ptr_q      <= 1'b0;
            occ_q[0]   <= '0;
            occ_q[1]   <= '0;
        end else begin
            s1_valid_q <= |grant;
            if (|grant) begin
                s1_owner_q <= grant[1];
                s1_q       <= sel_req;
            end
            ptr_q    <= ptr_d;
            occ_q[0] <= occ_d[0];
            occ_q[1] <= occ_d[1];
        end
    end

    alu #(.WIDTH(DATA_WIDTH)) u_alu (
        .ctrl_i (s1_q.ctrl),
        .op1_i  (s1_q.op1),
        .op2_i  (s1_q.op2),
        .sum_o  (alu_sum),
        .eq_o   (alu_eq)
    );

    // The ALU passes op1 through on unused encodings; those must return 0.
    assign alu_rsp.result = ctrl_defined(s1_q.ctrl) ? alu_sum : '0;
    assign alu_rsp.eq     = alu_eq;

    for (genvar g = 0; g < 2; g++) begin : g_port
        assign push[g] = s1_valid_q & (s1_owner_q == 1'(g));

        alu_rsp_fifo #(.entry_t(rsp_t)) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (push[g]),
            .din_i   (alu_rsp),
            .pop_i   (pop[g]),
            .head_o  (fifo_head[g]),
            .full_o  (fifo_full[g]),
            .empty_o (fifo_empty[g]),
            .count_o (fifo_count_unused[g])
        );

        assign rsp_valid[g] = ~fifo_empty[g];
        assign rsp_result[DATA_WIDTH*g +: DATA_WIDTH] =
            rsp_valid[g] ? fifo_head[g].result : '0;
        assign rsp_eq[g] = rsp_valid[g] & fifo_head[g].eq;
    end

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_ctrl;
    logic [63:0] req_op1;
    logic [63:0] req_op2;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [63:0] rsp_result;
    logic [1:0]  rsp_eq;

    int errors = 0;
    int checks = 0;

    alu_share_arb #(.DATA_WIDTH(32), .RSP_DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ctrl   (req_ctrl),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_eq     (rsp_eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] res;
        logic        eq;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        req_ctrl[3*p +: 3] = c;
        req_op1[32*p +: 32] = a;
        req_op2[32*p +: 32] = b;
    endtask

    function automatic logic [31:0] res(input int p);
        return rsp_result[32*p +: 32];
    endfunction

    // Structural invariants: occupancy bounded, no push into a full FIFO.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (dut.occ_q[i] > 2'd2) begin
                    checks++;
                    errors++;
                    $display("FAIL occ_bound p%0d: got %0d expected <=2", i, dut.occ_q[i]);
                end
                if (dut.push[i] && dut.fifo_full[i]) begin
                    checks++;
                    errors++;
                    $display("FAIL fifo_overflow p%0d: got push to full expected none", i);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{3'b000, 32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1] = '{3'b001, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0};
        vecs[2] = '{3'b010, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0};
        vecs[3] = '{3'b011, 32'h0F0F_0000,  32'h0000_00F0,  32'h0F0F_00F0,  1'b0};
        vecs[4] = '{3'b100, 32'h0000_00FF,  32'h0000_00FF,  32'h0,          1'b1};
        vecs[5] = '{3'b000, 32'hFFFF_FFFF,  32'h1,          32'h0,          1'b0};
        vecs[6] = '{3'b110, 32'h1234,       32'h1234,       32'h0,          1'b1};
        vecs[7] = '{3'b101, 32'd7,          32'd3,          32'h0,          1'b0};
        vecs[8] = '{3'b111, 32'hAAAA_5555,  32'hAAAA_5555,  32'h0,          1'b1};
        vecs[9] = '{3'b001, 32'h0,          32'h1,          32'hFFFF_FFFF,  1'b0};

        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        req_ctrl  = '0;
        req_op1   = '0;
        req_op2   = '0;

        // Reset state, with both requesters already valid
        set_req(0, 3'b001, 32'd3, 32'd5);
        set_req(1, 3'b100, 32'hFF, 32'hFF);
        req_valid = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_result", rsp_result, 64'h0);
        check("rst_rsp_eq", 64'(rsp_eq), 64'h0);

        // Simultaneous requests at reset release: port 0 first
        rst_n = 1'b1;
        #1;
        check("sim_grant_p0", 64'(req_ready), 64'h1);
        tick();
        check("sim_grant_p1", 64'(req_ready), 64'h2);
        tick();
        req_valid = 2'b00;
        #1;
        check("sim_p0_valid", 64'(rsp_valid), 64'h1);
        check("sim_p0_result", 64'(res(0)), 64'hFFFF_FFFE);
        check("sim_p0_eq", 64'(rsp_eq[0]), 64'h0);
        tick();
        check("sim_p1_valid", 64'(rsp_valid), 64'h2);
        check("sim_p1_result", 64'(res(1)), 64'h0);
        check("sim_p1_eq", 64'(rsp_eq[1]), 64'h1);
        tick();
        check("sim_drained", 64'(rsp_valid), 64'h0);

        // Continuous valid on both ports alternates grants
        set_req(0, 3'b000, 32'd1, 32'd1);
        set_req(1, 3'b000, 32'd2, 32'd2);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("alt_grant%0d", k), 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
            tick();
        end
        req_valid = 2'b00;
        repeat (4) tick();

        // Directed vector table, one op at a time on each port
        for (int p = 0; p < 2; p++) begin
            for (int v = 0; v < 10; v++) begin
                set_req(p, vecs[v].ctrl, vecs[v].op1, vecs[v].op2);
                req_valid = 2'(1 << p);
                #1;
                check($sformatf("vec%0d_p%0d_ready", v, p), 64'(req_ready), 64'(1 << p));
                tick();
                req_valid = 2'b00;
                #1;
                check($sformatf("vec%0d_p%0d_lat1", v, p), 64'(rsp_valid), 64'h0);
                tick();
                check($sformatf("vec%0d_p%0d_valid", v, p), 64'(rsp_valid), 64'(1 << p));
                check($sformatf("vec%0d_p%0d_res", v, p), 64'(res(p)), 64'(vecs[v].res));
                check($sformatf("vec%0d_p%0d_eq", v, p), 64'(rsp_eq[p]), 64'(vecs[v].eq));
                tick();
            end
        end

        // Backpressure on port 1 while port 0 streams
        rsp_ready = 2'b01;
        req_valid = 2'b11;
        for (int c = 0; c < 8; c++) begin
            set_req(0, 3'b000, 32'(1000 + c), 32'd0);
            set_req(1, 3'b000, 32'(100 + c), 32'd0);
            #1;
            check($sformatf("bp_grant%0d", c), 64'(req_ready), (c == 1 || c == 3) ? 64'h2 : 64'h1);
            if (c >= 3) begin
                check($sformatf("bp_p1_valid%0d", c), 64'(rsp_valid[1]), 64'h1);
                check($sformatf("bp_p1_head%0d", c), 64'(res(1)), 64'd101);
            end
            if (c >= 6) begin
                check($sformatf("bp_p0_valid%0d", c), 64'(rsp_valid[0]), 64'h1);
                check($sformatf("bp_p0_res%0d", c), 64'(res(0)), 64'(1000 + c - 2));
            end
            tick();
        end
        set_req(0, 3'b000, 32'd1008, 32'd0);
        set_req(1, 3'b000, 32'd108, 32'd0);
        rsp_ready = 2'b11;
        #1;
        check("bp_regrant_p1", 64'(req_ready), 64'h2);
        check("bp_head_before_pop", 64'(res(1)), 64'd101);
        tick();
        req_valid = 2'b00;
        #1;
        check("bp_head_after_pop", 64'(res(1)), 64'd103);
        check("bp_p1_still_valid", 64'(rsp_valid[1]), 64'h1);
        repeat (6) tick();

        // Reset while an op sits in stage 1 and one in FIFO 0
        rsp_ready = 2'b00;
        set_req(0, 3'b000, 32'd9, 32'd9);
        req_valid = 2'b01;
        tick();
        set_req(0, 3'b000, 32'd8, 32'd8);
        tick();
        #1;
        check("mid_pre_valid", 64'(rsp_valid), 64'h1);
        set_req(0, 3'b000, 32'd40, 32'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rsp_valid), 64'h0);
        check("mid_rst_ready", 64'(req_ready), 64'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_acc1_ready", 64'(req_ready), 64'h1);
        check("mid_acc1_valid", 64'(rsp_valid), 64'h0);
        tick();
        check("mid_acc2_ready", 64'(req_ready), 64'h1);
        check("mid_acc2_valid", 64'(rsp_valid), 64'h0);
        tick();
        check("mid_full_ready", 64'(req_ready), 64'h0);
        check("mid_new_valid", 64'(rsp_valid), 64'h1);
        check("mid_new_result", 64'(res(0)), 64'd42);
        rsp_ready = 2'b01;
        #1;
        check("mid_pop_regrant", 64'(req_ready), 64'h1);
        req_valid = 2'b00;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
